// File: rtl/floo_pkg.sv
// Shared types and helpers for the FlooNoC virtual-channel link adapter.
package floo_pkg;

    typedef logic [2:0] vc_id_t;

    localparam int unsigned MaxNumVC        = 8;
    localparam int unsigned DefaultVCDepth  = 2;
    localparam int unsigned DefaultCntWidth = $clog2(DefaultVCDepth + 1);

    // Width needed to hold a count from 0 up to and including depth
    function automatic int unsigned credit_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/floo_vc_ingress_fifo.sv
// Per-VC ingress buffer; a push into a full FIFO is only accepted with a pop in the same cycle.
// FLOO_VC_ADAPTER_ERR_EN adds the drop_o overflow indication.
module floo_vc_ingress_fifo
    import floo_pkg::*;
#(
    parameter int unsigned Depth  = 2,
    parameter type         flit_t = logic
) (
    input  logic  clk_i,
    input  logic  rst_i,
    input  logic  push_i,
    input  flit_t data_i,
    input  logic  pop_i,
    output flit_t data_o,
`ifdef FLOO_VC_ADAPTER_ERR_EN
    output logic  drop_o,
`endif
    output logic  empty_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = credit_width(Depth);

    flit_t           mem_r [Depth];
    logic [PtrW-1:0] wr_ptr_r;
    logic [PtrW-1:0] rd_ptr_r;
    logic [CntW-1:0] cnt_r;
    logic            full_s;
    logic            push_ok_s;
    logic            pop_ok_s;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (32'(p) == Depth - 1) ? '0 : p + PtrW'(1'b1);
    endfunction

    assign empty_o   = (cnt_r == '0);
    assign full_s    = (cnt_r == CntW'(Depth));
    assign push_ok_s = push_i & (~full_s | pop_i);
    assign pop_ok_s  = pop_i & ~empty_o;
    assign data_o    = mem_r[rd_ptr_r];

`ifdef FLOO_VC_ADAPTER_ERR_EN
    assign drop_o = push_i & full_s & ~pop_i;
`endif

    // Storage array write port
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                mem_r[i] <= '0;
            end
        end else if (push_ok_s) begin
            mem_r[wr_ptr_r] <= data_i;
        end
    end

    // Read/write pointers and occupancy
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            cnt_r    <= '0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   cnt_r <= cnt_r + CntW'(1'b1);
                2'b01:   cnt_r <= cnt_r - CntW'(1'b1);
                default: cnt_r <= cnt_r;
            endcase
        end
    end

endmodule

// File: rtl/floo_vc_link_adapter.sv
// Credit-based VC link adapter between a chimney (valid/ready) and a router link.
// Define FLOO_VC_ADAPTER_ERR_EN to build the sticky protocol-error flag err_o.
module floo_vc_link_adapter
    import floo_pkg::*;
#(
    parameter int unsigned NumVC    = 2,
    parameter int unsigned VCDepth  = 2,
    parameter int unsigned CntWidth = credit_width(VCDepth),
    parameter type         flit_t   = logic,
    parameter type         vc_id_t  = floo_pkg::vc_id_t
) (
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   eg_valid_i,
    output logic   eg_ready_o,
    input  flit_t  eg_data_i,
    input  vc_id_t eg_vc_i,
    output logic   data_v_o,
    output flit_t  data_o,
    output vc_id_t vc_id_o,
    input  logic   credit_v_i,
    input  vc_id_t credit_id_i,
    input  logic   data_v_i,
    input  flit_t  data_i,
    input  vc_id_t vc_id_i,
    output logic   credit_v_o,
    output vc_id_t credit_id_o,
    output logic   in_valid_o,
    input  logic   in_ready_i,
    output flit_t  in_data_o,
    output logic   err_o
);

    logic [CntWidth-1:0] credit_r     [NumVC];
    logic [CntWidth-1:0] credit_nxt_s [NumVC];
    logic [NumVC-1:0]    credit_dec_s;
    logic [NumVC-1:0]    credit_inc_s;
    logic                eg_credit_nz_s;
    logic                eg_fire_s;

    logic [NumVC-1:0]    push_s;
    logic [NumVC-1:0]    pop_s;
    logic [NumVC-1:0]    empty_s;
    flit_t               head_s [NumVC];
    vc_id_t              rr_ptr_r;
    vc_id_t              lock_vc_r;
    logic                lock_r;
    vc_id_t              grant_s;
    logic                grant_v_s;
    logic                pop_fire_s;
    logic [31:0]         dist_s;
    logic [31:0]         best_s;
    logic                sel_s;

`ifdef FLOO_VC_ADAPTER_ERR_EN
    logic [NumVC-1:0]    drop_s;
    logic                err_evt_s;
    logic                err_r;
`endif

    // Credit lookup for the requested egress VC; out-of-range VCs never match
    always_comb begin
        eg_credit_nz_s = 1'b0;
        for (int unsigned v = 0; v < NumVC; v++) begin
            eg_credit_nz_s = eg_credit_nz_s | ((32'(eg_vc_i) == v) && (credit_r[v] != '0));
        end
    end

    assign eg_ready_o = eg_credit_nz_s;
    assign eg_fire_s  = eg_valid_i & eg_ready_o;

    // Next credit count; a return to a full counter saturates
    always_comb begin
        for (int unsigned v = 0; v < NumVC; v++) begin
            credit_dec_s[v] = eg_fire_s && (32'(eg_vc_i) == v);
            credit_inc_s[v] = credit_v_i && (32'(credit_id_i) == v);
            credit_nxt_s[v] = credit_r[v];
            if (credit_dec_s[v] && credit_inc_s[v]) begin
                credit_nxt_s[v] = credit_r[v];
            end else if (credit_dec_s[v]) begin
                credit_nxt_s[v] = credit_r[v] - CntWidth'(1'b1);
            end else if (credit_inc_s[v] && (credit_r[v] != CntWidth'(VCDepth))) begin
                credit_nxt_s[v] = credit_r[v] + CntWidth'(1'b1);
            end else begin
                credit_nxt_s[v] = credit_r[v];
            end
        end
    end

    // Credit counters start full: the downstream buffers are empty after reset
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned v = 0; v < NumVC; v++) begin
                credit_r[v] <= CntWidth'(VCDepth);
            end
        end else begin
            for (int unsigned v = 0; v < NumVC; v++) begin
                credit_r[v] <= credit_nxt_s[v];
            end
        end
    end

    // Egress link register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_v_o <= 1'b0;
            data_o   <= '0;
            vc_id_o  <= '0;
        end else begin
            data_v_o <= eg_fire_s;
            if (eg_fire_s) begin
                data_o  <= eg_data_i;
                vc_id_o <= eg_vc_i;
            end
        end
    end

    // Ingress push demux and pop decode
    always_comb begin
        for (int unsigned v = 0; v < NumVC; v++) begin
            push_s[v] = data_v_i && (32'(vc_id_i) == v);
            pop_s[v]  = pop_fire_s && (32'(grant_s) == v);
        end
    end

    for (genvar g = 0; g < NumVC; g++) begin : gen_fifo
        floo_vc_ingress_fifo #(
            .Depth  (VCDepth),
            .flit_t (flit_t)
        ) u_fifo (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .push_i  (push_s[g]),
            .data_i  (data_i),
            .pop_i   (pop_s[g]),
            .data_o  (head_s[g]),
`ifdef FLOO_VC_ADAPTER_ERR_EN
            .drop_o  (drop_s[g]),
`endif
            .empty_o (empty_s[g])
        );
    end

    // Round-robin pick, frozen while a presented flit waits for in_ready_i
    always_comb begin
        grant_v_s = 1'b0;
        grant_s   = '0;
        best_s    = 32'(NumVC);
        dist_s    = 32'd0;
        sel_s     = 1'b0;
        if (lock_r) begin
            grant_v_s = 1'b1;
            grant_s   = lock_vc_r;
        end else begin
            for (int unsigned v = 0; v < NumVC; v++) begin
                dist_s    = (v + NumVC - 32'(rr_ptr_r)) % NumVC;
                sel_s     = !empty_s[v] && (dist_s < best_s);
                best_s    = sel_s ? dist_s : best_s;
                grant_s   = sel_s ? vc_id_t'(v) : grant_s;
                grant_v_s = grant_v_s | sel_s;
            end
        end
    end

    assign in_valid_o = grant_v_s;
    assign pop_fire_s = grant_v_s & in_ready_i;

    // Ingress data mux on the granted VC
    always_comb begin
        in_data_o = '0;
        for (int unsigned v = 0; v < NumVC; v++) begin
            in_data_o = (32'(grant_s) == v) ? head_s[v] : in_data_o;
        end
    end

    // Arbiter pointer and grant lock
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr_r  <= '0;
            lock_r    <= 1'b0;
            lock_vc_r <= '0;
        end else begin
            lock_r    <= grant_v_s & ~in_ready_i;
            lock_vc_r <= grant_s;
            if (pop_fire_s) begin
                rr_ptr_r <= (32'(grant_s) + 32'd1 == NumVC) ? '0 : vc_id_t'(32'(grant_s) + 32'd1);
            end
        end
    end

    // Credit return towards the router, one cycle after each pop
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            credit_v_o  <= 1'b0;
            credit_id_o <= '0;
        end else begin
            credit_v_o <= pop_fire_s;
            if (pop_fire_s) begin
                credit_id_o <= grant_s;
            end
        end
    end

`ifdef FLOO_VC_ADAPTER_ERR_EN
    // Gather this cycle's protocol violations
    always_comb begin
        err_evt_s = (|drop_s)
                  | (eg_valid_i && (32'(eg_vc_i) >= NumVC))
                  | (data_v_i && (32'(vc_id_i) >= NumVC))
                  | (credit_v_i && (32'(credit_id_i) >= NumVC));
        for (int unsigned v = 0; v < NumVC; v++) begin
            err_evt_s = err_evt_s
                      | (credit_inc_s[v] && !credit_dec_s[v] && (credit_r[v] == CntWidth'(VCDepth)));
        end
    end

    // Sticky error flag, cleared only by reset
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_r <= 1'b0;
        end else begin
            err_r <= err_r | err_evt_s;
        end
    end

    assign err_o = err_r;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_floo_vc_link_adapter.sv
// Directed self-checking bench for floo_vc_link_adapter (NumVC=2, VCDepth=2, 8-bit flits).
module tb_floo_vc_link_adapter;

    localparam logic ERR_EXP =
`ifdef FLOO_VC_ADAPTER_ERR_EN
        1'b1;
`else
        1'b0;
`endif

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       eg_valid_i;
    logic       eg_ready_o;
    logic [7:0] eg_data_i;
    logic [2:0] eg_vc_i;
    logic       data_v_o;
    logic [7:0] data_o;
    logic [2:0] vc_id_o;
    logic       credit_v_i;
    logic [2:0] credit_id_i;
    logic       data_v_i;
    logic [7:0] data_i;
    logic [2:0] vc_id_i;
    logic       credit_v_o;
    logic [2:0] credit_id_o;
    logic       in_valid_o;
    logic       in_ready_i;
    logic [7:0] in_data_o;
    logic       err_o;

    int total_cnt = 0;
    int bad_cnt   = 0;

    floo_vc_link_adapter #(
        .NumVC   (2),
        .VCDepth (2),
        .flit_t  (logic [7:0])
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .eg_valid_i  (eg_valid_i),
        .eg_ready_o  (eg_ready_o),
        .eg_data_i   (eg_data_i),
        .eg_vc_i     (eg_vc_i),
        .data_v_o    (data_v_o),
        .data_o      (data_o),
        .vc_id_o     (vc_id_o),
        .credit_v_i  (credit_v_i),
        .credit_id_i (credit_id_i),
        .data_v_i    (data_v_i),
        .data_i      (data_i),
        .vc_id_i     (vc_id_i),
        .credit_v_o  (credit_v_o),
        .credit_id_o (credit_id_o),
        .in_valid_o  (in_valid_o),
        .in_ready_i  (in_ready_i),
        .in_data_o   (in_data_o),
        .err_o       (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_i = 1'b1; eg_valid_i = 1'b0; eg_data_i = 8'h00; eg_vc_i = 3'd0;
        credit_v_i = 1'b0; credit_id_i = 3'd0; data_v_i = 1'b0; data_i = 8'h00;
        vc_id_i = 3'd0; in_ready_i = 1'b0;
        #12;
        check_eq("rst_data_v", data_v_o, 1'b0);
        check_eq("rst_data", data_o, 8'h00);
        check_eq("rst_vc_id", vc_id_o, 3'd0);
        check_eq("rst_credit_v", credit_v_o, 1'b0);
        check_eq("rst_credit_id", credit_id_o, 3'd0);
        check_eq("rst_in_valid", in_valid_o, 1'b0);
        check_eq("rst_err", err_o, 1'b0);
        check_eq("rst_ready", eg_ready_o, 1'b1);
        @(negedge clk_i) rst_i = 1'b0;

        // Three flits on VC0 with two credits
        eg_valid_i = 1'b1; eg_vc_i = 3'd0; eg_data_i = 8'hA1;
        #1 check_eq("eg_rdy1", eg_ready_o, 1'b1);
        tick();
        check_eq("eg_v1", data_v_o, 1'b1);
        check_eq("eg_d1", data_o, 8'hA1);
        check_eq("eg_vc1", vc_id_o, 3'd0);
        @(negedge clk_i) eg_data_i = 8'hA2;
        #1 check_eq("eg_rdy2", eg_ready_o, 1'b1);
        tick();
        check_eq("eg_d2", data_o, 8'hA2);
        @(negedge clk_i) eg_data_i = 8'hA3;
        #1 check_eq("eg_rdy3", eg_ready_o, 1'b0);
        tick();
        check_eq("eg_v3_blocked", data_v_o, 1'b0);
        @(negedge clk_i) begin credit_v_i = 1'b1; credit_id_i = 3'd0; end
        #1 check_eq("eg_rdy_cred_same", eg_ready_o, 1'b0);
        tick();
        check_eq("eg_v_wait", data_v_o, 1'b0);
        @(negedge clk_i) credit_v_i = 1'b0;
        #1 check_eq("eg_rdy_after_cred", eg_ready_o, 1'b1);
        tick();
        check_eq("eg_v3", data_v_o, 1'b1);
        check_eq("eg_d3", data_o, 8'hA3);
        @(negedge clk_i) begin eg_valid_i = 1'b0; eg_vc_i = 3'd1; end
        #1 check_eq("eg_rdy_vc1", eg_ready_o, 1'b1);
        eg_vc_i = 3'd0;
        #1 check_eq("eg_rdy_vc0_empty", eg_ready_o, 1'b0);
        credit_v_i = 1'b1; credit_id_i = 3'd0;
        tick(); tick();
        @(negedge clk_i) credit_v_i = 1'b0;

        // VC1: transfer with a same-cycle credit return
        eg_valid_i = 1'b1; eg_vc_i = 3'd1; eg_data_i = 8'hB1;
        tick();
        check_eq("vc1_v", data_v_o, 1'b1);
        check_eq("vc1_id", vc_id_o, 3'd1);
        @(negedge clk_i) begin eg_data_i = 8'hB2; credit_v_i = 1'b1; credit_id_i = 3'd1; end
        #1 check_eq("vc1_rdy_a", eg_ready_o, 1'b1);
        tick();
        check_eq("vc1_d2", data_o, 8'hB2);
        @(negedge clk_i) begin credit_v_i = 1'b0; eg_data_i = 8'hB3; end
        #1 check_eq("vc1_rdy_same_cycle", eg_ready_o, 1'b1);
        tick();
        @(negedge clk_i) eg_valid_i = 1'b0;
        #1 check_eq("vc1_rdy_empty", eg_ready_o, 1'b0);
        credit_v_i = 1'b1; credit_id_i = 3'd1;
        tick(); tick();
        @(negedge clk_i) credit_v_i = 1'b0;

        // Credit return to a full counter saturates
        credit_v_i = 1'b1; credit_id_i = 3'd0;
        tick();
        check_eq("sat_err", err_o, ERR_EXP);
        @(negedge clk_i) begin credit_v_i = 1'b0; eg_valid_i = 1'b1; eg_vc_i = 3'd0; eg_data_i = 8'hC1; end
        tick();
        @(negedge clk_i) eg_data_i = 8'hC2;
        tick();
        @(negedge clk_i);
        #1 check_eq("sat_cap", eg_ready_o, 1'b0);

        // Reset with a flit on the link and one in an ingress FIFO
        eg_vc_i = 3'd1; eg_data_i = 8'hD1;
        data_v_i = 1'b1; vc_id_i = 3'd0; data_i = 8'h77; in_ready_i = 1'b0;
        tick();
        check_eq("pre_rst_data_v", data_v_o, 1'b1);
        check_eq("pre_rst_in_valid", in_valid_o, 1'b1);
        eg_valid_i = 1'b0; data_v_i = 1'b0; rst_i = 1'b1;
        #1;
        check_eq("mid_rst_data_v", data_v_o, 1'b0);
        check_eq("mid_rst_in_valid", in_valid_o, 1'b0);
        check_eq("mid_rst_credit_v", credit_v_o, 1'b0);
        check_eq("mid_rst_err", err_o, 1'b0);
        eg_vc_i = 3'd0;
        #1 check_eq("mid_rst_cnt0", eg_ready_o, 1'b1);
        @(negedge clk_i) rst_i = 1'b0;

        // Ingress: one flit on VC0 then one on VC1
        in_ready_i = 1'b1; data_v_i = 1'b1; vc_id_i = 3'd0; data_i = 8'h11;
        #1 check_eq("push_latency", in_valid_o, 1'b0);
        tick();
        check_eq("ing_v0", in_valid_o, 1'b1);
        check_eq("ing_d0", in_data_o, 8'h11);
        @(negedge clk_i) begin vc_id_i = 3'd1; data_i = 8'h22; end
        tick();
        check_eq("cred_v0", credit_v_o, 1'b1);
        check_eq("cred_id0", credit_id_o, 3'd0);
        check_eq("ing_d1", in_data_o, 8'h22);
        @(negedge clk_i) data_v_i = 1'b0;
        tick();
        check_eq("cred_v1", credit_v_o, 1'b1);
        check_eq("cred_id1", credit_id_o, 3'd1);
        check_eq("ing_idle", in_valid_o, 1'b0);
        tick();
        check_eq("cred_idle", credit_v_o, 1'b0);

        // Presented flit stays stable while in_ready_i is low
        @(negedge clk_i) begin in_ready_i = 1'b0; data_v_i = 1'b1; vc_id_i = 3'd1; data_i = 8'hF1; end
        tick();
        @(negedge clk_i) begin vc_id_i = 3'd0; data_i = 8'hF0; end
        tick();
        check_eq("hold_valid", in_valid_o, 1'b1);
        check_eq("hold_data", in_data_o, 8'hF1);
        @(negedge clk_i) begin data_v_i = 1'b0; in_ready_i = 1'b1; end
        tick();
        check_eq("hold_cred_id", credit_id_o, 3'd1);
        check_eq("hold_next", in_data_o, 8'hF0);
        tick();
        check_eq("hold_cred_id2", credit_id_o, 3'd0);

        // Round robin: pointer sits at VC1 after the VC0 pop
        @(negedge clk_i) begin in_ready_i = 1'b0; data_v_i = 1'b1; vc_id_i = 3'd0; data_i = 8'h31; end
        tick();
        @(negedge clk_i) begin vc_id_i = 3'd1; data_i = 8'h32; end
        tick();
        @(negedge clk_i) begin vc_id_i = 3'd0; data_i = 8'h33; end
        tick();
        @(negedge clk_i) begin data_v_i = 1'b0; in_ready_i = 1'b1; end
        #1 check_eq("rr_first", in_data_o, 8'h31);
        tick();
        check_eq("rr_second", in_data_o, 8'h32);
        tick();
        check_eq("rr_third", in_data_o, 8'h33);
        check_eq("rr_cred1", credit_id_o, 3'd1);
        tick();
        check_eq("rr_empty", in_valid_o, 1'b0);

        // Overflow drop, then push+pop on a full FIFO
        @(negedge clk_i) begin in_ready_i = 1'b0; data_v_i = 1'b1; vc_id_i = 3'd0; data_i = 8'h41; end
        tick();
        @(negedge clk_i) data_i = 8'h42;
        tick();
        @(negedge clk_i) data_i = 8'h43;
        tick();
        check_eq("ovf_err", err_o, ERR_EXP);
        @(negedge clk_i) begin in_ready_i = 1'b1; data_i = 8'h44; end
        #1 check_eq("ovf_head", in_data_o, 8'h41);
        tick();
        check_eq("full_pp_head", in_data_o, 8'h42);
        check_eq("full_pp_cred", credit_v_o, 1'b1);
        @(negedge clk_i) data_v_i = 1'b0;
        tick();
        check_eq("full_pp_tail", in_data_o, 8'h44);
        tick();
        check_eq("full_pp_empty", in_valid_o, 1'b0);

        // Out-of-range VC indices are ignored
        @(negedge clk_i) rst_i = 1'b1;
        @(negedge clk_i) begin
            rst_i = 1'b0; eg_valid_i = 1'b1; eg_vc_i = 3'd5;
            data_v_i = 1'b1; vc_id_i = 3'd3; data_i = 8'h55;
        end
        #1 check_eq("bad_vc_ready", eg_ready_o, 1'b0);
        tick();
        check_eq("bad_vc_data_v", data_v_o, 1'b0);
        check_eq("bad_vc_in_valid", in_valid_o, 1'b0);
        check_eq("bad_vc_err", err_o, ERR_EXP);
        @(negedge clk_i) begin eg_valid_i = 1'b0; data_v_i = 1'b0; end

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
